// File: rtl/efuse_req_arb.sv
// efuse_req_arb: shares the single efuse_ctrl command port between NREQ requesters.
// Requester 0 has fixed priority; requesters 1..NREQ-1 are served round-robin.
module efuse_req_arb #(
    parameter int NREQ     = 3,
    parameter int NW       = 64,
    parameter int NR       = 64,
    parameter int TO_START = 16,
    parameter int TO_DONE  = 4096,
    localparam int SELW    = $clog2(256 / NW),
    localparam int RSELW   = $clog2(256 / NR)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       req_mode,
    input  logic [RSELW*NREQ-1:0]   req_rsel,
    input  logic [SELW*NREQ-1:0]    req_wsel,
    input  logic [NW*NREQ-1:0]      req_wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [NREQ-1:0]         err,
    output logic [NR-1:0]           rsp_rdata,
    output logic                    ctrl_start,
    output logic [1:0]              ctrl_mode,
    output logic [RSELW-1:0]        ctrl_read_sel,
    output logic [SELW-1:0]         ctrl_write_sel,
    output logic [NW-1:0]           ctrl_wdata,
    input  logic                    ctrl_busy,
    input  logic [NR-1:0]           ctrl_rdata,
    output logic                    arb_busy
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TO_DONE) + 1;

    typedef enum logic [2:0] {
        IDLE, GRANT, LAUNCH, WAIT_BSY, WAIT_DONE, RESP
    } state_e;

    state_e            state_q;
    logic [NREQ-1:0]   gnt_q, done_q, err_q;
    logic [NR-1:0]     rdata_q;
    logic              start_q;
    logic [1:0]        mode_q;
    logic [RSELW-1:0]  rsel_q;
    logic [SELW-1:0]   wsel_q;
    logic [NW-1:0]     wdata_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     ptr_q, idx_q;

    logic              found_d;
    logic [NREQ-1:0]   oh_d;
    logic [IW-1:0]     idx_d, ptr_d;
    logic [1:0]        mode_d;
    logic [RSELW-1:0]  rsel_d;
    logic [SELW-1:0]   wsel_d;
    logic [NW-1:0]     wdata_d;
    logic [CW-1:0]     cnt_inc;

    // Round-robin scan starts at ptr_q and wraps NREQ-1 -> 1, never visiting 0.
    always_comb begin : select
        int unsigned j;
        j       = 0;
        found_d = 1'b0;
        oh_d    = '0;
        idx_d   = '0;
        if (req[0]) begin
            found_d = 1'b1;
            oh_d[0] = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NREQ - 1; k++) begin
                j = 32'(ptr_q) + k;
                if (j >= NREQ) j = j - (NREQ - 1);
                for (int unsigned i = 1; i < NREQ; i++) begin
                    if (!found_d && i == j && req[i]) begin
                        found_d = 1'b1;
                        oh_d[i] = 1'b1;
                        idx_d   = IW'(i);
                    end
                end
            end
        end
    end

    always_comb begin : cmd_mux
        mode_d  = '0;
        rsel_d  = '0;
        wsel_d  = '0;
        wdata_d = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (oh_d[i]) begin
                mode_d  = req_mode[2*i +: 2];
                rsel_d  = req_rsel[RSELW*i +: RSELW];
                wsel_d  = req_wsel[SELW*i +: SELW];
                wdata_d = req_wdata[NW*i +: NW];
            end
        end
    end

    assign ptr_d   = (idx_q == IW'(NREQ - 1)) ? IW'(1) : idx_q + IW'(1);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            start_q <= 1'b0;
            mode_q  <= '0;
            rsel_q  <= '0;
            wsel_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= IW'(1);
            idx_q   <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (!ctrl_busy && found_d) begin
                        gnt_q   <= oh_d;
                        idx_q   <= idx_d;
                        mode_q  <= mode_d;
                        rsel_q  <= rsel_d;
                        wsel_q  <= wsel_d;
                        wdata_q <= wdata_d;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (mode_q[1]) begin
                        err_q   <= gnt_q;
                        state_q <= RESP;
                    end else begin
                        start_q <= 1'b1;
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_BSY;
                end
                WAIT_BSY: begin
                    if (ctrl_busy) begin
                        cnt_q   <= '0;
                        state_q <= WAIT_DONE;
                    end else if (cnt_q == CW'(TO_START - 1)) begin
                        err_q   <= gnt_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                WAIT_DONE: begin
                    if (!ctrl_busy) begin
                        done_q <= gnt_q;
                        if (mode_q == 2'd0) rdata_q <= ctrl_rdata;
                        state_q <= RESP;
                    end else if (cnt_q == CW'(TO_DONE - 1)) begin
                        err_q   <= gnt_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                RESP: begin
                    gnt_q <= '0;
                    if (idx_q != '0) ptr_q <= ptr_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt            = gnt_q;
    assign done           = done_q;
    assign err            = err_q;
    assign rsp_rdata      = rdata_q;
    assign ctrl_start     = start_q;
    assign ctrl_mode      = mode_q;
    assign ctrl_read_sel  = rsel_q;
    assign ctrl_write_sel = wsel_q;
    assign ctrl_wdata     = wdata_q;
    assign arb_busy       = (state_q != IDLE);

endmodule
